zube_shift_frame: RTL and testbench
===================================

# zube_shift_frame

Chip-select-gated, full-duplex serial framing register for the zube test-chip I/O slot, replacing the single-bit `data_in` → `data_out` flip-flop. While `cs` is high it shifts a configurable-width word in on `data_in` and out on `data_out`. Each completed received frame is presented as a parallel word with a one-cycle valid strobe. Frames aborted by `cs` dropping early are discarded and flagged.

## Interface
Parameters:
- `WIDTH`, default 8: payload bits per frame; legal range 2–32.
- `MSB_FIRST`, default 1: 1 = MSB shifted first on both directions; 0 = LSB first.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `cs` in 1: frame enable, active-high, sampled on `clk`.
- `data_in` in 1: serial receive bit, sampled on edges where `cs` is high.
- `data_out` out 1: serial transmit bit, registered.
- `load` in 1: write `load_data` into the transmit buffer.
- `load_data` in WIDTH: next word to transmit.
- `par_out` out WIDTH: last completed received word.
- `par_valid` out 1: one-cycle pulse when `par_out` updates.
- `frame_err` out 1: one-cycle pulse on an aborted frame.
- `par_err` out 1: parity mismatch pulse; tied 0 unless parity is compiled in.

## Operation
- FSM states:
  - IDLE: `cs` low.
  - SHIFT: frame in progress.
- FSM transitions:
  - IDLE→SHIFT on an edge with `cs`=1.
  - SHIFT→IDLE on an edge with `cs`=0.
- Bit counter `cnt` runs 0..FLEN-1.
  - FLEN = WIDTH, or WIDTH+1 with parity.
  - `cnt` increments on each `cs`=1 edge and wraps to 0 after FLEN-1.
  - A wrap starts the next frame immediately when `cs` stays high (back-to-back frames).
- Receive:
  - `rx_shift` takes `data_in` on every `cs`=1 edge.
  - On the edge where `cnt`=FLEN-1: `par_out` ← assembled payload, and `par_valid`=1 for the following cycle.
- Transmit:
  - On a frame-start edge (`cnt`=0, `cs`=1): `tx_shift` ← `tx_buf`, and `data_out` ← its first bit.
  - On later `cs`=1 edges, `data_out` ← next bit.
  - On any `cs`=0 edge, `data_out` ← 0.
- Transmit buffer:
  - `tx_buf` ← `load_data` on any edge with `load`=1.
  - If `load` coincides with a frame-start edge, `load_data` is used directly (bypass).
  - `tx_buf` persists: an unreloaded buffer is retransmitted.
- Abort:
  - SHIFT→IDLE with `cnt`≠0 pulses `frame_err` for one cycle, discards the partial word, leaves `par_out` unchanged and resets `cnt` to 0.
  - `cs` falling with `cnt`=0 (clean boundary) is not an error.
- Reset:
  - All registers clear: state IDLE, `cnt`=0, `tx_buf`=0, `par_out`=0.
  - All strobes are 0 and `data_out`=0.
  - `data_out` is also forced 0 combinationally while `reset` is high.
  - Reset mid-frame discards the frame without `frame_err`.

## Timing
- Bit n (0-based) of the outgoing frame is on `data_out` in the cycle after the n-th `cs`=1 edge.
- Receive latency: `par_out` and `par_valid` are valid the cycle after the last frame bit is sampled.
- `frame_err` is asserted the cycle after the `cs`=0 edge.
- `par_valid` and `frame_err` are never high together.
- No idle cycles are required between frames. Minimum frame period is FLEN cycles.

## Configuration
- Macro `ZUBE_PARITY_EN`, when defined:
  - FLEN = WIDTH+1.
  - Transmit appends an even-parity bit over the payload.
  - Receive checks the final bit and pulses `par_err` together with `par_valid` on mismatch.
  - `par_out` is updated regardless of the parity result.
- When undefined: FLEN = WIDTH, `par_err` is constant 0, and no parity logic is present.

## Structure
- `zube_pkg`:
  - FSM state typedef (IDLE, SHIFT).
  - Counter-width constant/function, `$clog2(WIDTH+1)`.
- One sub-module, `zube_frame_counter`, containing the bit counter with wrap and clear, plus the frame-start and frame-end decodes.
- Shift registers, parity and the FSM stay in the top module.

## Test plan
- Reset: hold `reset` 3 cycles with `cs`=1 and `data_in`=1 → `data_out`=0 throughout; after release `par_out`=0 and no strobes.
- Round trip (WIDTH=8, MSB_FIRST=1): load 0xA5, hold `cs` 8 cycles, drive bits 0x3C → `data_out` shows 1,0,1,0,0,1,0,1; `par_out`=0x3C with one `par_valid` pulse.
- Back-to-back: `cs` high for 16 cycles with 0x11 then 0x22 → two `par_valid` pulses 8 cycles apart, with `par_out` = 0x11 then 0x22; `tx_buf` is retransmitted in frame two.
- Abort: drop `cs` after 5 bits → `frame_err` for one cycle, `par_out` unchanged; the next full frame is received correctly starting at `cnt`=0.
- Bypass: assert `load` with 0xF0 on the frame-start edge → that same frame transmits 0xF0.
- With `ZUBE_PARITY_EN`: send 0x07 followed by parity bit 0 → `par_valid` and `par_err` pulse together, `par_out`=0x07.

Source files
------------

// File: rtl/zube_pkg.sv
// Shared types and helpers for the zube serial framing register.
package zube_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Enough bits for a counter that may reach WIDTH (the parity slot).
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/zube_frame_counter.sv
// Bit counter for one frame: counts cs-high edges, wraps after FLEN-1, clears when cs drops.
module zube_frame_counter
    import zube_pkg::*;
#(
    parameter int FLEN = 8,
    parameter int CW   = cnt_width(FLEN)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cs,
    output logic [CW-1:0] cnt,
    output logic          frame_start,
    output logic          frame_end
);

    assign frame_start = cs && (cnt == '0);
    assign frame_end   = cs && (cnt == CW'(FLEN - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (cs) begin
            cnt <= frame_end ? '0 : cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/zube_shift_frame.sv
// Chip-select-gated full-duplex framing register with parallel receive word.
// Optional even parity slot is compiled in with the ZUBE_PARITY_EN macro.
module zube_shift_frame
    import zube_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             data_in,
    output logic             data_out,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    output logic             frame_err,
    output logic             par_err
);

`ifdef ZUBE_PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif
    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             frame_start;
    logic             frame_end;
    logic [WIDTH-1:0] rx_shift;
    logic [WIDTH-1:0] rx_next;
    logic [WIDTH-1:0] rx_word;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-1:0] tx_buf;
    logic [WIDTH-1:0] tx_word;
    logic             data_out_q;

    zube_frame_counter #(
        .FLEN(FLEN),
        .CW  (CW)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .cs         (cs),
        .cnt        (cnt),
        .frame_start(frame_start),
        .frame_end  (frame_end)
    );

    // A load on the frame-start edge bypasses the buffer so the new word goes out immediately.
    always_comb begin
        tx_word = load ? load_data : tx_buf;
        if (MSB_FIRST) begin
            rx_next = {rx_shift[WIDTH-2:0], data_in};
        end else begin
            rx_next = {data_in, rx_shift[WIDTH-1:1]};
        end
`ifdef ZUBE_PARITY_EN
        rx_word = rx_shift;
`else
        rx_word = rx_next;
`endif
    end

    assign data_out = data_out_q & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            par_out   <= '0;
            par_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            par_valid <= frame_end;
            frame_err <= 1'b0;
            if (frame_end) begin
                par_out <= rx_word;
            end
            case (state)
                IDLE: begin
                    if (cs) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!cs) begin
                        state     <= IDLE;
                        frame_err <= (cnt != '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ZUBE_PARITY_EN
    logic tx_par;
    logic par_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_par    <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            if (frame_start) begin
                tx_par <= ^tx_word;
            end
            par_err_q <= frame_end && (data_in != ^rx_shift);
        end
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_shift   <= '0;
            tx_shift   <= '0;
            tx_buf     <= '0;
            data_out_q <= 1'b0;
        end else begin
            if (load) begin
                tx_buf <= load_data;
            end
            if (cs) begin
                rx_shift <= rx_next;
                if (frame_start) begin
                    if (MSB_FIRST) begin
                        data_out_q <= tx_word[WIDTH-1];
                        tx_shift   <= {tx_word[WIDTH-2:0], 1'b0};
                    end else begin
                        data_out_q <= tx_word[0];
                        tx_shift   <= {1'b0, tx_word[WIDTH-1:1]};
                    end
`ifdef ZUBE_PARITY_EN
                end else if (cnt == CW'(WIDTH)) begin
                    data_out_q <= tx_par;
`endif
                end else if (MSB_FIRST) begin
                    data_out_q <= tx_shift[WIDTH-1];
                    tx_shift   <= {tx_shift[WIDTH-2:0], 1'b0};
                end else begin
                    data_out_q <= tx_shift[0];
                    tx_shift   <= {1'b0, tx_shift[WIDTH-1:1]};
                end
            end else begin
                data_out_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_zube_shift_frame.sv
// Directed bench for zube_shift_frame (WIDTH=8, MSB first); honours ZUBE_PARITY_EN.
module tb_zube_shift_frame;

    localparam int WIDTH = 8;
`ifdef ZUBE_PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             cs;
    logic             data_in;
    logic             data_out;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] par_out;
    logic             par_valid;
    logic             frame_err;
    logic             par_err;

    int total = 0;
    int bad   = 0;

    zube_shift_frame #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cs       (cs),
        .data_in  (data_in),
        .data_out (data_out),
        .load     (load),
        .load_data(load_data),
        .par_out  (par_out),
        .par_valid(par_valid),
        .frame_err(frame_err),
        .par_err  (par_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic applyStimulus(input logic c, input logic d, input logic l, input logic [WIDTH-1:0] ld);
        cs        = c;
        data_in   = d;
        load      = l;
        load_data = ld;
        @(posedge clk);
        #1;
    endtask

    // One full frame with cs held high; the parity bit (if present) can be corrupted with flip.
    task automatic sendFrame(input string name, input logic [WIDTH-1:0] rx_word,
                             input logic [WIDTH-1:0] exp_tx, input logic bypass,
                             input logic [WIDTH-1:0] bypass_val, input logic flip);
        for (int i = 0; i < FLEN; i++) begin
            logic rx_bit;
            logic tx_bit;
            if (i < WIDTH) begin
                rx_bit = rx_word[WIDTH-1-i];
                tx_bit = exp_tx[WIDTH-1-i];
            end else begin
                rx_bit = (^rx_word) ^ flip;
                tx_bit = ^exp_tx;
            end
            applyStimulus(1'b1, rx_bit, bypass && (i == 0), bypass_val);
            checkOutput($sformatf("%s_dout%0d", name, i), 32'(data_out), 32'(tx_bit));
            if (i < FLEN - 1) begin
                checkOutput($sformatf("%s_valid_early%0d", name, i), 32'(par_valid), 32'd0);
            end else begin
                checkOutput({name, "_valid"}, 32'(par_valid), 32'd1);
                checkOutput({name, "_par_out"}, 32'(par_out), 32'(rx_word));
                checkOutput({name, "_par_err"}, 32'(par_err), 32'(flip));
                checkOutput({name, "_frame_err"}, 32'(frame_err), 32'd0);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        cs        = 1'b1;
        data_in   = 1'b1;
        load      = 1'b0;
        load_data = '0;
        #1;
        checkOutput("reset_dout_comb", 32'(data_out), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, '0);
            checkOutput($sformatf("reset_dout%0d", i), 32'(data_out), 32'd0);
        end

        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("post_reset_par_out", 32'(par_out), 32'h0);
        checkOutput("post_reset_valid", 32'(par_valid), 32'd0);
        checkOutput("post_reset_frame_err", 32'(frame_err), 32'd0);
        checkOutput("post_reset_par_err", 32'(par_err), 32'd0);
        checkOutput("post_reset_dout", 32'(data_out), 32'd0);

        // Round trip: transmit 0xA5 while receiving 0x3C.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hA5);
        sendFrame("rt", 8'h3C, 8'hA5, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("clean_end_frame_err", 32'(frame_err), 32'd0);
        checkOutput("clean_end_valid", 32'(par_valid), 32'd0);
        checkOutput("clean_end_dout", 32'(data_out), 32'd0);

        // Back-to-back frames; buffer is retransmitted in both.
        sendFrame("b2b1", 8'h11, 8'hA5, 1'b0, '0, 1'b0);
        sendFrame("b2b2", 8'h22, 8'hA5, 1'b0, '0, 1'b0);

        // Abort after 5 bits of the following frame.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, '0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("abort_frame_err", 32'(frame_err), 32'd1);
        checkOutput("abort_valid", 32'(par_valid), 32'd0);
        checkOutput("abort_par_out", 32'(par_out), 32'h22);
        checkOutput("abort_dout", 32'(data_out), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("abort_pulse_end", 32'(frame_err), 32'd0);
        sendFrame("after_abort", 8'h5A, 8'hA5, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);

        // Bypass load on the frame-start edge, then the new buffer persists.
        sendFrame("bypass", 8'hC3, 8'hF0, 1'b1, 8'hF0, 1'b0);
        sendFrame("persist", 8'h99, 8'hF0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);

`ifdef ZUBE_PARITY_EN
        sendFrame("parity_bad", 8'h07, 8'hF0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("parity_err_pulse_end", 32'(par_err), 32'd0);
`endif

        // Reset mid-frame discards silently and clears the transmit buffer.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, '0);
        end
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        checkOutput("midreset_dout", 32'(data_out), 32'd0);
        checkOutput("midreset_par_out", 32'(par_out), 32'h0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("midreset_no_frame_err", 32'(frame_err), 32'd0);
        checkOutput("midreset_no_valid", 32'(par_valid), 32'd0);
        sendFrame("after_reset", 8'h81, 8'h00, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
